// File: rtl/ahb_pkg.sv
package ahb_pkg;

  typedef enum logic [1:0] {
    HT_IDLE   = 2'b00,
    HT_BUSY   = 2'b01,
    HT_NONSEQ = 2'b10,
    HT_SEQ    = 2'b11
  } htrans_t;

  localparam logic [2:0] HBURST_SINGLE = 3'b000;
  localparam logic [2:0] HBURST_INCR   = 3'b001;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_XFER,
    ST_LAST,
    ST_ERR
  } state_t;

  function automatic logic [2:0] hsize_of(input int unsigned data_w);
    case (data_w)
      8:       return 3'd0;
      16:      return 3'd1;
      32:      return 3'd2;
      64:      return 3'd3;
      default: return 3'd2;
    endcase
  endfunction

endpackage

// File: rtl/ahb_addr_gen.sv
// Burst address register: loads the first beat address, steps by one word,
// flags when the next address starts a new 1 KB region.
module ahb_addr_gen #(
  parameter int ADDR_W = 32,
  parameter int STEP   = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic [ADDR_W-1:0] load_addr,
  input  logic              inc,
  output logic [ADDR_W-1:0] addr,
  output logic              next_boundary
);

  logic [ADDR_W-1:0] addr_q, addr_d, addr_next;

  assign addr_next     = addr_q + ADDR_W'(STEP);
  assign next_boundary = (addr_next[9:0] == 10'd0);
  assign addr          = addr_q;

  always_comb begin
    addr_d = addr_q;
    if (load)
      addr_d = load_addr;
    else if (inc)
      addr_d = addr_next;
  end

  always_ff @(posedge clk) begin
    if (rst)
      addr_q <= '0;
    else
      addr_q <= addr_d;
  end

endmodule

// File: rtl/ahb_burst_master.sv
// AHB-Lite INCR burst master with pipelined address/data phases.
module ahb_burst_master
  import ahb_pkg::*;
#(
  parameter  int ADDR_W    = 32,
  parameter  int DATA_W    = 32,
  parameter  int MAX_BEATS = 16,
  localparam int BEAT_W    = $clog2(MAX_BEATS + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              re,
  input  logic              we,
  input  logic [ADDR_W-1:0] start_addr,
  input  logic [BEAT_W-1:0] num_beats,
  input  logic [DATA_W-1:0] wdata,
  output logic              wdata_pop,
  output logic [DATA_W-1:0] rdata_out,
  output logic              rdata_valid,
  output logic              busy,
  output logic              read_complete,
  output logic              write_complete,
  output logic              error,
  output logic [ADDR_W-1:0] haddr,
  output logic [1:0]        htrans,
  output logic              hwrite,
  output logic [2:0]        hsize,
  output logic [2:0]        hburst,
  output logic [DATA_W-1:0] hwdata,
  input  logic [DATA_W-1:0] hrdata,
  input  logic              hready,
  input  logic              hresp
);

  localparam logic [2:0] HSIZE = hsize_of(DATA_W);

  state_t            state_q, state_d;
  htrans_t           htrans_q, htrans_d;
  logic [BEAT_W-1:0] beat_cnt_q, beat_cnt_d;
  logic [BEAT_W-1:0] num_q, num_d;
  logic              dphase_q, dphase_d;
  logic              hwrite_q, hwrite_d;
  logic [2:0]        hsize_q, hsize_d;
  logic [2:0]        hburst_q, hburst_d;
  logic [DATA_W-1:0] hwdata_q, hwdata_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              rvalid_q, rvalid_d;
  logic              pop_q, pop_d;
  logic              busy_q, busy_d;
  logic              rc_q, rc_d;
  logic              wc_q, wc_d;
  logic              err_q, err_d;

  logic ag_load, ag_inc, ag_boundary;
  logic abort;

  ahb_addr_gen #(
    .ADDR_W(ADDR_W),
    .STEP  (DATA_W / 8)
  ) u_addr_gen (
    .clk          (clk),
    .rst          (rst),
    .load         (ag_load),
    .load_addr    (start_addr),
    .inc          (ag_inc),
    .addr         (haddr),
    .next_boundary(ag_boundary)
  );

  // ERROR only matters while a data phase is in flight.
  assign abort = hresp && ((state_q == ST_XFER && dphase_q) || state_q == ST_LAST);

  always_comb begin
    state_d    = state_q;
    htrans_d   = htrans_q;
    beat_cnt_d = beat_cnt_q;
    num_d      = num_q;
    dphase_d   = dphase_q;
    hwrite_d   = hwrite_q;
    hsize_d    = hsize_q;
    hburst_d   = hburst_q;
    hwdata_d   = hwdata_q;
    rdata_d    = rdata_q;
    busy_d     = busy_q;
    rvalid_d   = 1'b0;
    pop_d      = 1'b0;
    rc_d       = 1'b0;
    wc_d       = 1'b0;
    err_d      = 1'b0;
    ag_load    = 1'b0;
    ag_inc     = 1'b0;

    if (abort) begin
      htrans_d = HT_IDLE;
      dphase_d = 1'b0;
      if (hready) begin
        err_d   = 1'b1;
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end else begin
        state_d = ST_ERR;
      end
    end else begin
      case (state_q)
        ST_IDLE: begin
          if ((re || we) && num_beats != '0) begin
            ag_load    = 1'b1;
            htrans_d   = HT_NONSEQ;
            hwrite_d   = ~re;
            hsize_d    = HSIZE;
            hburst_d   = (num_beats == BEAT_W'(1)) ? HBURST_SINGLE : HBURST_INCR;
            busy_d     = 1'b1;
            beat_cnt_d = BEAT_W'(1);
            num_d      = num_beats;
            dphase_d   = 1'b0;
            state_d    = ST_XFER;
          end
        end
        ST_XFER: begin
          if (hready) begin
            if (hwrite_q) begin
              hwdata_d = wdata;
              pop_d    = 1'b1;
            end
            if (dphase_q && !hwrite_q) begin
              rdata_d  = hrdata;
              rvalid_d = 1'b1;
            end
            dphase_d = 1'b1;
            if (beat_cnt_q == num_q) begin
              htrans_d = HT_IDLE;
              state_d  = ST_LAST;
            end else begin
              ag_inc     = 1'b1;
              htrans_d   = ag_boundary ? HT_NONSEQ : HT_SEQ;
              beat_cnt_d = beat_cnt_q + 1'b1;
            end
          end
        end
        ST_LAST: begin
          if (hready) begin
            if (!hwrite_q) begin
              rdata_d  = hrdata;
              rvalid_d = 1'b1;
            end
            rc_d     = ~hwrite_q;
            wc_d     = hwrite_q;
            busy_d   = 1'b0;
            dphase_d = 1'b0;
            state_d  = ST_IDLE;
          end
        end
        ST_ERR: begin
          if (hready) begin
            err_d   = 1'b1;
            busy_d  = 1'b0;
            state_d = ST_IDLE;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      htrans_q   <= HT_IDLE;
      beat_cnt_q <= '0;
      num_q      <= '0;
      dphase_q   <= 1'b0;
      hwrite_q   <= 1'b0;
      hsize_q    <= '0;
      hburst_q   <= '0;
      hwdata_q   <= '0;
      rdata_q    <= '0;
      rvalid_q   <= 1'b0;
      pop_q      <= 1'b0;
      busy_q     <= 1'b0;
      rc_q       <= 1'b0;
      wc_q       <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      htrans_q   <= htrans_d;
      beat_cnt_q <= beat_cnt_d;
      num_q      <= num_d;
      dphase_q   <= dphase_d;
      hwrite_q   <= hwrite_d;
      hsize_q    <= hsize_d;
      hburst_q   <= hburst_d;
      hwdata_q   <= hwdata_d;
      rdata_q    <= rdata_d;
      rvalid_q   <= rvalid_d;
      pop_q      <= pop_d;
      busy_q     <= busy_d;
      rc_q       <= rc_d;
      wc_q       <= wc_d;
      err_q      <= err_d;
    end
  end

  assign htrans         = htrans_q;
  assign hwrite         = hwrite_q;
  assign hsize          = hsize_q;
  assign hburst         = hburst_q;
  assign hwdata         = hwdata_q;
  assign rdata_out      = rdata_q;
  assign rdata_valid    = rvalid_q;
  assign wdata_pop      = pop_q;
  assign busy           = busy_q;
  assign read_complete  = rc_q;
  assign write_complete = wc_q;
  assign error          = err_q;

endmodule

// File: tb/tb_ahb_burst_master.sv
module tb_ahb_burst_master;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int BEAT_W = 5;
  localparam logic [1:0] T_IDLE   = 2'b00;
  localparam logic [1:0] T_NONSEQ = 2'b10;
  localparam logic [1:0] T_SEQ    = 2'b11;

  logic              clk = 1'b0;
  logic              rst, re, we, hready, hresp;
  logic [ADDR_W-1:0] start_addr, haddr;
  logic [BEAT_W-1:0] num_beats;
  logic [DATA_W-1:0] wdata, rdata_out, hwdata, hrdata;
  logic              wdata_pop, rdata_valid, busy, read_complete, write_complete, error, hwrite;
  logic [1:0]        htrans;
  logic [2:0]        hsize, hburst;

  int n_checks = 0;
  int n_fail   = 0;

  ahb_burst_master #(
    .ADDR_W   (ADDR_W),
    .DATA_W   (DATA_W),
    .MAX_BEATS(16)
  ) dut (
    .clk(clk), .rst(rst), .re(re), .we(we), .start_addr(start_addr),
    .num_beats(num_beats), .wdata(wdata), .wdata_pop(wdata_pop),
    .rdata_out(rdata_out), .rdata_valid(rdata_valid), .busy(busy),
    .read_complete(read_complete), .write_complete(write_complete),
    .error(error), .haddr(haddr), .htrans(htrans), .hwrite(hwrite),
    .hsize(hsize), .hburst(hburst), .hwdata(hwdata), .hrdata(hrdata),
    .hready(hready), .hresp(hresp)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b1; re = 1'b0; we = 1'b0; hready = 1'b1; hresp = 1'b0;
    start_addr = '0; num_beats = '0; wdata = '0; hrdata = '0;
    tick; tick;
    rst = 1'b0;
    n_checks++; if (htrans !== T_IDLE) begin n_fail++; $display("FAIL reset_htrans: got %b want %b", htrans, T_IDLE); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
    n_checks++; if (haddr !== 32'h0) begin n_fail++; $display("FAIL reset_haddr: got %h want 0", haddr); end
    n_checks++; if ({wdata_pop, rdata_valid, read_complete, write_complete, error, hwrite} !== 6'b0) begin
      n_fail++; $display("FAIL reset_pulses: got %b want 000000",
                         {wdata_pop, rdata_valid, read_complete, write_complete, error, hwrite});
    end
    n_checks++; if ({hsize, hburst, hwdata} !== 38'h0) begin n_fail++; $display("FAIL reset_regs: got %h want 0", {hsize, hburst, hwdata}); end
  endtask

  task automatic test_single_write;
    we = 1'b1; start_addr = 32'h100; num_beats = 5'd1; wdata = 32'hAAAAAAAA;
    tick;
    we = 1'b0;
    n_checks++; if (haddr !== 32'h100) begin n_fail++; $display("FAIL sw_haddr: got %h want 100", haddr); end
    n_checks++; if (htrans !== T_NONSEQ) begin n_fail++; $display("FAIL sw_htrans: got %b want 10", htrans); end
    n_checks++; if ({hburst, hwrite, hsize, busy} !== {3'b000, 1'b1, 3'd2, 1'b1}) begin
      n_fail++; $display("FAIL sw_ctrl: got %b want 000101 01", {hburst, hwrite, hsize, busy});
    end
    tick;
    n_checks++; if (wdata_pop !== 1'b1) begin n_fail++; $display("FAIL sw_pop: got %b want 1", wdata_pop); end
    n_checks++; if (hwdata !== 32'hAAAAAAAA) begin n_fail++; $display("FAIL sw_hwdata: got %h want aaaaaaaa", hwdata); end
    n_checks++; if (htrans !== T_IDLE) begin n_fail++; $display("FAIL sw_htrans_last: got %b want 00", htrans); end
    tick;
    n_checks++; if ({write_complete, busy, wdata_pop} !== 3'b100) begin
      n_fail++; $display("FAIL sw_done: got wc/busy/pop %b want 100", {write_complete, busy, wdata_pop});
    end
    tick;
    n_checks++; if (write_complete !== 1'b0) begin n_fail++; $display("FAIL sw_wc_pulse: got %b want 0", write_complete); end
  endtask

  // Four-beat zero-wait read; trpat holds the expected htrans of beat i at [2*i+:2].
  task automatic do_read4(input string nm, input logic [31:0] sa, input logic [7:0] trpat);
    logic [127:0] rd;
    rd = {32'h55555555, 32'hAAAAAAAA, 32'h00000000, 32'hFFFFFFFF};
    re = 1'b1; start_addr = sa; num_beats = 5'd4;
    tick;
    re = 1'b0;
    n_checks++; if ({hwrite, hburst} !== 4'b0001) begin n_fail++; $display("FAIL %s_ctrl: got %b want 0001", nm, {hwrite, hburst}); end
    for (int i = 0; i < 4; i++) begin
      n_checks++; if (haddr !== sa + 32'(4 * i)) begin
        n_fail++; $display("FAIL %s_haddr%0d: got %h want %h", nm, i, haddr, sa + 32'(4 * i));
      end
      n_checks++; if (htrans !== trpat[2*i +: 2]) begin
        n_fail++; $display("FAIL %s_htrans%0d: got %b want %b", nm, i, htrans, trpat[2*i +: 2]);
      end
      if (i >= 2) begin
        n_checks++; if ({rdata_valid, rdata_out} !== {1'b1, rd[32*(i-2) +: 32]}) begin
          n_fail++; $display("FAIL %s_rdata%0d: got %b/%h want 1/%h", nm, i - 2, rdata_valid, rdata_out, rd[32*(i-2) +: 32]);
        end
      end else begin
        n_checks++; if (rdata_valid !== 1'b0) begin n_fail++; $display("FAIL %s_rvalid_early%0d: got %b want 0", nm, i, rdata_valid); end
      end
      hrdata = (i > 0) ? rd[32*(i-1) +: 32] : 32'h0;
      tick;
    end
    n_checks++; if ({htrans, rdata_valid, rdata_out, read_complete} !== {T_IDLE, 1'b1, rd[64 +: 32], 1'b0}) begin
      n_fail++; $display("FAIL %s_last: got %b/%b/%h/%b want 00/1/%h/0", nm, htrans, rdata_valid, rdata_out, read_complete, rd[64 +: 32]);
    end
    hrdata = rd[96 +: 32];
    tick;
    n_checks++; if ({rdata_valid, rdata_out, read_complete, busy} !== {1'b1, rd[96 +: 32], 1'b1, 1'b0}) begin
      n_fail++; $display("FAIL %s_done: got %b/%h/%b/%b want 1/%h/1/0", nm, rdata_valid, rdata_out, read_complete, busy, rd[96 +: 32]);
    end
    tick;
  endtask

  task automatic test_read4;
    do_read4("rd4", 32'h0, {T_SEQ, T_SEQ, T_SEQ, T_NONSEQ});
  endtask

  task automatic test_boundary;
    do_read4("bnd", 32'h3F8, {T_SEQ, T_NONSEQ, T_SEQ, T_NONSEQ});
  endtask

  task automatic test_write_stall;
    logic [31:0] words [4];
    logic        rdy_tab [7];
    int          pops;
    words   = '{32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444};
    rdy_tab = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
    pops = 0;
    we = 1'b1; start_addr = 32'h200; num_beats = 5'd4; wdata = words[0];
    tick;
    we = 1'b0;
    for (int c = 1; c <= 7; c++) begin
      if (wdata_pop === 1'b1) begin
        pops++;
        n_checks++; if (hwdata !== words[pops-1]) begin n_fail++; $display("FAIL ws_hwdata%0d: got %h want %h", pops, hwdata, words[pops-1]); end
        if (pops < 4) wdata = words[pops];
      end
      if (c == 3 || c == 4) begin
        n_checks++; if ({haddr, htrans, hwdata} !== {32'h204, T_SEQ, 32'h11111111}) begin
          n_fail++; $display("FAIL ws_stall%0d: got %h/%b/%h want 204/11/11111111", c, haddr, htrans, hwdata);
        end
      end
      if (c == 5) begin
        n_checks++; if (haddr !== 32'h208) begin n_fail++; $display("FAIL ws_haddr_resume: got %h want 208", haddr); end
      end
      if (c == 7) begin
        n_checks++; if ({htrans, write_complete} !== {T_IDLE, 1'b0}) begin
          n_fail++; $display("FAIL ws_last: got %b/%b want 00/0", htrans, write_complete);
        end
      end
      hready = rdy_tab[c-1];
      tick;
    end
    hready = 1'b1;
    if (wdata_pop === 1'b1) pops++;
    n_checks++; if ({write_complete, busy} !== 2'b10) begin n_fail++; $display("FAIL ws_done: got %b want 10", {write_complete, busy}); end
    n_checks++; if (pops !== 4) begin n_fail++; $display("FAIL ws_pops: got %0d want 4", pops); end
    tick;
  endtask

  task automatic test_error;
    int pops;
    pops = 0;
    we = 1'b1; start_addr = 32'h300; num_beats = 5'd8; wdata = 32'hDEAD0000;
    tick;
    we = 1'b0;
    tick;
    if (wdata_pop === 1'b1) pops++;
    tick;
    if (wdata_pop === 1'b1) pops++;
    n_checks++; if (haddr !== 32'h308) begin n_fail++; $display("FAIL er_haddr: got %h want 308", haddr); end
    hresp = 1'b1; hready = 1'b0;
    tick;
    if (wdata_pop === 1'b1) pops++;
    n_checks++; if ({htrans, error} !== {T_IDLE, 1'b0}) begin n_fail++; $display("FAIL er_first: got %b/%b want 00/0", htrans, error); end
    hready = 1'b1;
    tick;
    if (wdata_pop === 1'b1) pops++;
    hresp = 1'b0;
    n_checks++; if ({error, busy, write_complete} !== 3'b100) begin
      n_fail++; $display("FAIL er_pulse: got %b want 100", {error, busy, write_complete});
    end
    n_checks++; if (pops !== 2) begin n_fail++; $display("FAIL er_pops: got %0d want 2", pops); end
    re = 1'b1; start_addr = 32'h40; num_beats = 5'd1;
    tick;
    re = 1'b0;
    n_checks++; if ({haddr, htrans, hwrite, busy, error} !== {32'h40, T_NONSEQ, 1'b0, 1'b1, 1'b0}) begin
      n_fail++; $display("FAIL er_next: got %h/%b/%b/%b/%b want 40/10/0/1/0", haddr, htrans, hwrite, busy, error);
    end
    tick; tick;
    n_checks++; if ({read_complete, write_complete} !== 2'b10) begin
      n_fail++; $display("FAIL er_next_done: got %b want 10", {read_complete, write_complete});
    end
    tick;
  endtask

  task automatic test_re_we;
    int pops;
    pops = 0;
    re = 1'b1; we = 1'b1; start_addr = 32'h500; num_beats = 5'd2;
    tick;
    re = 1'b0; we = 1'b0;
    n_checks++; if ({hwrite, hburst, htrans} !== {1'b0, 3'b001, T_NONSEQ}) begin
      n_fail++; $display("FAIL rw_ctrl: got %b want 000110", {hwrite, hburst, htrans});
    end
    for (int c = 0; c < 3; c++) begin
      tick;
      if (wdata_pop === 1'b1) pops++;
    end
    n_checks++; if ({read_complete, write_complete, pops[0]} !== 3'b100) begin
      n_fail++; $display("FAIL rw_done: got rc/wc %b%b pops %0d want 10 pops 0", read_complete, write_complete, pops);
    end
    tick;
  endtask

  task automatic test_zero_beats;
    re = 1'b1; start_addr = 32'h600; num_beats = 5'd0;
    tick;
    n_checks++; if ({busy, htrans} !== {1'b0, T_IDLE}) begin n_fail++; $display("FAIL zb_first: got %b want 000", {busy, htrans}); end
    tick;
    re = 1'b0;
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL zb_second: got %b want 0", busy); end
  endtask

  task automatic test_reset_mid;
    re = 1'b1; start_addr = 32'h700; num_beats = 5'd8;
    tick;
    re = 1'b0;
    tick; tick;
    rst = 1'b1;
    tick;
    rst = 1'b0;
    n_checks++; if ({htrans, busy, haddr} !== {T_IDLE, 1'b0, 32'h0}) begin
      n_fail++; $display("FAIL rm_state: got %b/%b/%h want 00/0/0", htrans, busy, haddr);
    end
    tick;
    n_checks++; if ({read_complete, write_complete, error, busy} !== 4'b0) begin
      n_fail++; $display("FAIL rm_after: got %b want 0000", {read_complete, write_complete, error, busy});
    end
  endtask

  initial begin
    test_reset;
    test_single_write;
    test_read4;
    test_write_stall;
    test_boundary;
    test_error;
    test_re_we;
    test_zero_beats;
    test_reset_mid;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ahb_burst_master.md
Name: ahb_burst_master

Overview:
Parametrised AHB-Lite master; successor to the single-beat AHB master used between the edge-detection buffers and SRAM. Accepts one read or write command of 1..MAX_BEATS beats and issues an INCR burst with pipelined address/data phases. Supports hready wait states, two-cycle ERROR response abort and 1 KB boundary splitting. Write data comes from a show-ahead buffer; read data is streamed out beat by beat.

Parameters:
ADDR_W, 32, address width
DATA_W, 32, data width; one of 8/16/32/64; hsize = log2(DATA_W/8)
MAX_BEATS, 16, maximum beats per command; BEAT_W = $clog2(MAX_BEATS+1)

Ports:
clk  in  1  system clock, rising edge
rst  in  1  synchronous active-high reset
re  in  1  read command request, sampled in IDLE
we  in  1  write command request, sampled in IDLE
start_addr  in  ADDR_W  first beat address, DATA_W/8-aligned
num_beats  in  BEAT_W  beat count, 1..MAX_BEATS
wdata  in  DATA_W  head word of write buffer (show-ahead)
wdata_pop  out  1  one-cycle pulse: head word consumed
rdata_out  out  DATA_W  captured read beat
rdata_valid  out  1  one-cycle pulse per read beat
busy  out  1  high from command accept until return to IDLE
read_complete  out  1  one-cycle pulse, read burst done
write_complete  out  1  one-cycle pulse, write burst done
error  out  1  one-cycle pulse, burst aborted by hresp
haddr  out  ADDR_W  AHB address
htrans  out  2  AHB transfer type
hwrite  out  1  AHB direction
hsize  out  3  AHB size
hburst  out  3  SINGLE when num_beats=1, else INCR
hwdata  out  DATA_W  AHB write data
hrdata  in  DATA_W  AHB read data
hready  in  1  AHB ready
hresp  in  1  AHB response, 1 = ERROR

Behaviour:
- Reset (clk edge with rst=1, any state, including mid-burst): all outputs 0, htrans=IDLE, state IDLE; no complete/error pulse. Partial burst is discarded.
- All outputs registered.
- States: IDLE, XFER (address phase, possibly overlapping data phase of the previous beat), LAST (data phase of the final beat only), ERR (second cycle of ERROR response).
- IDLE: command accepted when re|we and num_beats!=0; re&we -> read wins (hwrite=0). num_beats=0 -> ignored. re/we ignored outside IDLE.
- Cycle after accept: haddr=start_addr, htrans=NONSEQ, hwrite, hsize and hburst valid, busy=1.
- Address phase completes on a clk edge with hready=1. Next beat: haddr += DATA_W/8 (modulo 2^ADDR_W), htrans=SEQ; when the new address is 1 KB-aligned (haddr[9:0]==0), htrans=NONSEQ instead.
- hready=0: haddr, htrans, hwrite, hwdata held stable.
- Write: on completion of a write address phase, hwdata<=wdata and wdata_pop pulses on the same edge (exactly num_beats pops per burst).
- Read: on completion of a read data phase with hresp=0, rdata_out<=hrdata and rdata_valid pulses the following cycle.
- After the last address phase: htrans=IDLE, state LAST. When the last data phase completes, read_complete or write_complete pulses for one cycle, busy=0 and state IDLE. The next command can be accepted in the same cycle as the pulse.
- ERROR: on hresp=1 with hready=0, htrans<=IDLE next edge and the remaining beats are cancelled (state ERR). On hresp=1 with hready=1, error pulses and state returns to IDLE. No complete pulse; no further pops or rdata_valid.
- Beat counter: BEAT_W bits, counts address phases issued; no wrap past num_beats.

Decomposition:
- ahb_pkg: htrans_t enum (IDLE=2'b00, BUSY=2'b01, NONSEQ=2'b10, SEQ=2'b11); HBURST_SINGLE=3'b000, HBURST_INCR=3'b001; state_t enum; hsize function from DATA_W.
- Sub-module ahb_addr_gen: address register, increment by DATA_W/8, 1 KB boundary flag, wrap at 2^ADDR_W.

Test Plan:
- Single write: start_addr=0x100, num_beats=1, wdata=0xAAAAAAAA, hready=1 -> haddr=0x100, htrans=NONSEQ, hburst=SINGLE, hwrite=1; hwdata=0xAAAAAAAA next cycle; one wdata_pop; write_complete pulse; busy drops.
- 4-beat read, zero wait: start_addr=0x0, hrdata=0xFFFFFFFF,0x0,0xAAAAAAAA,0x55555555 -> haddr 0x0,0x4,0x8,0xC; htrans NONSEQ,SEQ,SEQ,SEQ; 4 rdata_valid pulses with matching data; read_complete after beat 4.
- 4-beat write with hready=0 for 2 cycles on beat 2 -> haddr/hwdata stable during the stall; exactly 4 pops; write_complete after 4 data phases.
- Boundary: start_addr=0x3F8, num_beats=4, read -> haddr 0x3F8,0x3FC,0x400,0x404; htrans NONSEQ,SEQ,NONSEQ,SEQ.
- hresp ERROR on beat 2 of an 8-beat write -> htrans=IDLE next cycle; error pulse; no write_complete; only 2 pops; next command accepted.
- re=we=1 -> hwrite=0, read executes. num_beats=0 -> busy stays 0. rst=1 mid-burst -> next edge htrans=IDLE, busy=0, no complete.
